// File: rtl/muxn_scan_pkg.sv
// Shared types and the wrap-around enabled-channel search for muxn_scan.
package muxn_pkg;

    typedef enum logic [1:0] {
        MANUAL,
        SCAN_DWELL,
        SCAN_PRESENT,
        SCAN_IDLE
    } state_t;

    // Upper bound on channel count supported by the search helper.
    localparam int unsigned MAXN = 32;
    localparam int unsigned IDXW = 5;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } next_t;

    // First set bit of mask at or after start, wrapping at n; start itself is inclusive.
    function automatic next_t next_enabled(input logic [MAXN-1:0] mask,
                                           input int unsigned     start,
                                           input int unsigned     n);
        next_t       r;
        int unsigned j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 0; i < MAXN; i++) begin
            if (i < n) begin
                j = start + i;
                if (j >= n) j = j - n;
                if (!r.found && mask[j[IDXW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[IDXW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/muxn_scan_if.sv
// Bus bundle between muxn_scan and its driver/consumer.
interface muxn_scan_if #(
    parameter int N = 4,
    parameter int W = 1
);
    localparam int SELW = $clog2(N);

    logic            mode;
    logic [SELW-1:0] sel;
    logic [N-1:0]    en_mask;
    logic [N*W-1:0]  din;
    logic [W-1:0]    y;
    logic [SELW-1:0] ch;
    logic            y_valid;
    logic            y_ready;
    logic            sel_err;

    modport master (
        output mode, sel, en_mask, din, y_ready,
        input  y, ch, y_valid, sel_err
    );

    modport slave (
        input  mode, sel, en_mask, din, y_ready,
        output y, ch, y_valid, sel_err
    );

endinterface

// File: rtl/muxn_scan_next_ch.sv
// Combinational wrap-around priority search over the channel enable mask.
module muxn_next_ch
    import muxn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          mask_i,
    input  logic [$clog2(N)-1:0]  start_i,
    output logic [$clog2(N)-1:0]  idx_o,
    output logic                  found_o
);
    localparam int SELW = $clog2(N);

    next_t res;

    always_comb begin
        res     = next_enabled(MAXN'(mask_i), 32'(start_i), N);
        idx_o   = SELW'(res.idx);
        found_o = res.found;
    end

endmodule

// File: rtl/muxn_scan.sv
// N-channel registered mux: manual select, or timed scan of enabled channels
// presenting one sample per channel through a valid/ready handshake.
module muxn_scan
    import muxn_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    muxn_scan_if.slave bus
);
    localparam int SELW = $clog2(N);
    localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [W-1:0]    y_q, y_d;
    logic            vld_q, vld_d;
    logic            err_q, err_d;

    logic [W-1:0]    din_a [N];
    logic [SELW-1:0] low_idx, nxt_idx, nxt_start;
    logic            low_found, nxt_found;
    logic            sel_oob;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign din_a[g] = bus.din[g*W +: W];
    end

    assign sel_oob   = 32'(bus.sel) >= 32'(N);
    assign nxt_start = (ch_q == SELW'(N-1)) ? '0 : ch_q + SELW'(1);

    muxn_next_ch #(.N(N)) u_lowest (
        .mask_i  (bus.en_mask),
        .start_i ('0),
        .idx_o   (low_idx),
        .found_o (low_found)
    );

    muxn_next_ch #(.N(N)) u_next (
        .mask_i  (bus.en_mask),
        .start_i (nxt_start),
        .idx_o   (nxt_idx),
        .found_o (nxt_found)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        y_d     = y_q;
        vld_d   = vld_q;
        err_d   = err_q;
        case (state_q)
            MANUAL: begin
                vld_d = 1'b0;
                if (bus.mode) begin
                    err_d = 1'b0;
                    if (low_found) begin
                        ch_d    = low_idx;
                        cnt_d   = '0;
                        state_d = SCAN_DWELL;
                    end else begin
                        state_d = SCAN_IDLE;
                    end
                end else if (sel_oob) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                    ch_d  = bus.sel;
                    y_d   = din_a[bus.sel];
                end
            end
            SCAN_DWELL: begin
                if (!bus.mode) begin
                    vld_d   = 1'b0;
                    state_d = MANUAL;
                end else begin
                    y_d   = din_a[ch_q];
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(SCAN_DIV-1)) begin
                        vld_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = SCAN_PRESENT;
                    end
                end
            end
            SCAN_PRESENT: begin
                // Leaving scan mode wins over a same-cycle accept; the sample is dropped.
                if (!bus.mode) begin
                    vld_d   = 1'b0;
                    state_d = MANUAL;
                end else if (bus.y_ready) begin
                    vld_d = 1'b0;
                    cnt_d = '0;
                    if (nxt_found) begin
                        ch_d    = nxt_idx;
                        state_d = SCAN_DWELL;
                    end else begin
                        state_d = SCAN_IDLE;
                    end
                end
            end
            SCAN_IDLE: begin
                vld_d = 1'b0;
                if (!bus.mode) begin
                    state_d = MANUAL;
                end else if (low_found) begin
                    ch_d    = low_idx;
                    cnt_d   = '0;
                    state_d = SCAN_DWELL;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            ch_q    <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.ch      = ch_q;
    assign bus.y_valid = vld_q;
    assign bus.sel_err = err_q;

endmodule

// File: tb/tb_muxn_scan.sv
// Self-checking bench for muxn_scan: directed scenarios plus randomized manual and scan runs.
module tb_muxn_scan;

    localparam int SCAN_DIV = 3;

    logic clk;
    logic rst_n;

    muxn_scan_if #(.N(4), .W(8)) bus4 ();
    muxn_scan_if #(.N(3), .W(8)) bus3 ();

    muxn_scan #(.N(4), .W(8), .SCAN_DIV(SCAN_DIV)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    muxn_scan #(.N(3), .W(8), .SCAN_DIV(SCAN_DIV)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
        return 8'((d >> (8 * i)) & 32'hFF);
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k]) return k;
        return 0;
    endfunction

    function automatic int next_after(input logic [3:0] m, input int c);
        for (int k = 1; k <= 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
        return c;
    endfunction

    // Steps until y_valid (bounded) and checks the number of cycles taken.
    task automatic wait_valid(input string tag, input int exp_n);
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus4.y_valid && n < 20);
        chk({tag, "_lat"}, n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [31:0] din4;
    logic [3:0]  mask;
    logic [7:0]  m3_y;
    int          m3_ch;
    logic        m3_err;
    int          s, exp_ch, gap;
    logic        in_pres, rdy;

    initial begin
        rst_n = 1'b1;
        bus4.mode = 1'b0; bus4.sel = '0; bus4.en_mask = '0; bus4.din = '0; bus4.y_ready = 1'b0;
        bus3.mode = 1'b0; bus3.sel = '0; bus3.en_mask = '0; bus3.din = '0; bus3.y_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_y", bus4.y, 0);
        chk("rst_ch", bus4.ch, 0);
        chk("rst_vld", bus4.y_valid, 0);
        chk("rst_err", bus4.sel_err, 0);
        chk("rst3_err", bus3.sel_err, 0);
        step();
        step();
        rst_n = 1'b1;

        // Manual select on both builds; N=3 flags sel=3 and holds.
        din4 = 32'hDDCCBBAA;
        bus4.din = din4;
        bus3.din = 24'hCCBBAA;
        m3_y = 8'h00; m3_ch = 0;
        for (int k = 0; k < 4; k++) begin
            bus4.sel = 2'(k);
            bus3.sel = 2'(k);
            if (k < 3) begin m3_y = byte_of(din4, k); m3_ch = k; m3_err = 1'b0; end
            else m3_err = 1'b1;
            step();
            chk("man_y", bus4.y, byte_of(din4, k));
            chk("man_ch", bus4.ch, k);
            chk("man_vld", bus4.y_valid, 0);
            chk("man_err", bus4.sel_err, 0);
            chk("man3_y", bus3.y, m3_y);
            chk("man3_ch", bus3.ch, m3_ch);
            chk("man3_err", bus3.sel_err, m3_err);
        end

        for (int k = 0; k < 16; k++) begin
            din4 = $urandom;
            s = int'($urandom_range(0, 3));
            bus4.din = din4; bus4.sel = 2'(s);
            bus3.din = 24'(din4); bus3.sel = 2'(s);
            if (s < 3) begin m3_y = byte_of(din4, s); m3_ch = s; m3_err = 1'b0; end
            else m3_err = 1'b1;
            step();
            chk("rman_y", bus4.y, byte_of(din4, s));
            chk("rman_ch", bus4.ch, s);
            chk("rman3_y", bus3.y, m3_y);
            chk("rman3_ch", bus3.ch, m3_ch);
            chk("rman3_err", bus3.sel_err, m3_err);
        end

        // Full scan, consumer always ready.
        din4 = 32'hDDCCBBAA;
        bus4.din = din4; bus4.sel = '0; bus4.en_mask = 4'b1111; bus4.y_ready = 1'b1;
        bus4.mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid("s1111", SCAN_DIV + 1);
            chk("s1111_ch", bus4.ch, k % 4);
            chk("s1111_y", bus4.y, byte_of(din4, k % 4));
            chk("s1111_err", bus4.sel_err, 0);
        end
        bus4.mode = 1'b0;
        step();
        chk("s1111_exit_vld", bus4.y_valid, 0);

        // Back-pressure on mask 1010.
        bus4.en_mask = 4'b1010; bus4.y_ready = 1'b0; bus4.mode = 1'b1;
        wait_valid("s1010a", SCAN_DIV + 1);
        chk("s1010a_ch", bus4.ch, 1);
        chk("s1010a_y", bus4.y, 8'hBB);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("s1010_hold_vld", bus4.y_valid, 1);
            chk("s1010_hold_y", bus4.y, 8'hBB);
            chk("s1010_hold_ch", bus4.ch, 1);
        end
        bus4.y_ready = 1'b1;
        wait_valid("s1010b", SCAN_DIV + 1);
        chk("s1010b_ch", bus4.ch, 3);
        chk("s1010b_y", bus4.y, 8'hDD);
        wait_valid("s1010c", SCAN_DIV + 1);
        chk("s1010c_ch", bus4.ch, 1);
        chk("s1010c_y", bus4.y, 8'hBB);
        bus4.mode = 1'b0; bus4.y_ready = 1'b0;
        step();
        chk("s1010_exit_vld", bus4.y_valid, 0);

        // Mask cleared mid-dwell: sample still presented, then idle until restored.
        bus4.en_mask = 4'b0011; bus4.mode = 1'b1;
        step();
        step();
        bus4.en_mask = 4'b0000;
        wait_valid("mz", 2);
        chk("mz_ch", bus4.ch, 0);
        chk("mz_y", bus4.y, 8'hAA);
        bus4.y_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mz_idle_vld", bus4.y_valid, 0);
            chk("mz_idle_ch", bus4.ch, 0);
        end
        bus4.en_mask = 4'b0100;
        wait_valid("mz_restore", SCAN_DIV + 1);
        chk("mz_restore_ch", bus4.ch, 2);
        chk("mz_restore_y", bus4.y, 8'hCC);
        bus4.mode = 1'b0; bus4.y_ready = 1'b0;
        step();

        // Asynchronous reset while presenting.
        bus4.en_mask = 4'b1100; bus4.mode = 1'b1;
        wait_valid("ar", SCAN_DIV + 1);
        chk("ar_pre_ch", bus4.ch, 2);
        chk("ar_pre_y", bus4.y, 8'hCC);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_y", bus4.y, 0);
        chk("ar_ch", bus4.ch, 0);
        chk("ar_vld", bus4.y_valid, 0);
        step();
        chk("ar_hold_vld", bus4.y_valid, 0);
        rst_n = 1'b1;
        wait_valid("ar_restart", SCAN_DIV + 1);
        chk("ar_restart_ch", bus4.ch, 2);
        chk("ar_restart_y", bus4.y, 8'hCC);
        bus4.mode = 1'b0;
        step();

        // Randomized scan against a handshake-level model.
        for (int t = 0; t < 4; t++) begin
            din4 = $urandom;
            mask = 4'($urandom_range(1, 15));
            bus4.din = din4; bus4.en_mask = mask;
            bus4.y_ready = 1'($urandom % 2);
            bus4.mode = 1'b1;
            exp_ch = lowest(mask); gap = 0; in_pres = 1'b0;
            for (int c = 0; c < 48; c++) begin
                step();
                if (bus4.y_valid) begin
                    if (!in_pres) chk("rs_gap", gap, SCAN_DIV);
                    chk("rs_ch", bus4.ch, exp_ch);
                    chk("rs_y", bus4.y, byte_of(din4, exp_ch));
                end else begin
                    gap++;
                end
                rdy = 1'($urandom % 2);
                bus4.y_ready = rdy;
                if (bus4.y_valid && rdy) begin
                    exp_ch = next_after(mask, exp_ch);
                    gap = 0;
                    in_pres = 1'b0;
                end else if (bus4.y_valid) begin
                    in_pres = 1'b1;
                end
            end
            bus4.mode = 1'b0; bus4.y_ready = 1'b0;
            step();
            chk("rs_exit_vld", bus4.y_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
